// File: rtl/circle_tick_gen.sv
// Step-rate generator for the circle animation: button sync/debounce,
// saturating speed level and the period counter that emits overflow_o.
module circle_tick_gen #(
    parameter int BASE_PERIOD     = 25000000,
    parameter int NUM_LEVELS      = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = $clog2(BASE_PERIOD),
    parameter int LVL_WIDTH       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 btn_faster_ni,
    input  logic                 btn_slower_ni,
    output logic                 overflow_o,
    output logic [LVL_WIDTH-1:0] level_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    if ((BASE_PERIOD >> (NUM_LEVELS - 1)) < 2) begin : g_bad_params
        $fatal(1, "circle_tick_gen: fastest period must be at least 2 cycles");
    end

    logic [1:0] btn_n;
    logic [1:0] press;

    assign btn_n = {btn_slower_ni, btn_faster_ni};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            sync1_q;
        logic            sync2_q;
        logic            stable_q;
        logic [DB_W-1:0] db_cnt_q;
        logic            db_done;

        // The press fires in the cycle the stable state is about to fall.
        assign db_done  = (sync2_q != stable_q) &&
                          (32'(db_cnt_q) == 32'(DEBOUNCE_CYCLES - 1));
        assign press[b] = db_done && !sync2_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync1_q  <= 1'b1;
                sync2_q  <= 1'b1;
                stable_q <= 1'b1;
                db_cnt_q <= '0;
            end else begin
                sync1_q <= btn_n[b];
                sync2_q <= sync1_q;
                if (sync2_q == stable_q) begin
                    db_cnt_q <= '0;
                end else if (db_done) begin
                    stable_q <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end
        end
    end

    logic [LVL_WIDTH-1:0] level_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_q;
    logic                 lvl_up;
    logic                 lvl_dn;
    logic                 lvl_chg;
    logic [31:0]          period_last;

    assign lvl_up  = press[0] && !press[1] &&
                     (32'(level_q) != 32'(NUM_LEVELS - 1));
    assign lvl_dn  = press[1] && !press[0] && (level_q != '0);
    assign lvl_chg = lvl_up || lvl_dn;

    assign period_last = (32'(BASE_PERIOD) >> level_q) - 32'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (lvl_up) begin
                level_q <= level_q + 1'b1;
            end else if (lvl_dn) begin
                level_q <= level_q - 1'b1;
            end

            // A new speed restarts the period even while paused.
            if (lvl_chg) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (!en_i) begin
                ovf_q <= 1'b0;
            end else if (32'(cnt_q) == period_last) begin
                cnt_q <= '0;
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                ovf_q <= 1'b0;
            end
        end
    end

    assign overflow_o = ovf_q;
    assign level_o    = level_q;

endmodule
